serial_paralelo: RTL and testbench

- Receive-side counterpart of the parallel-to-serial stage in the PCI physical layer; sits directly downstream of the serializer and consumes its 1-bit serial stream at clk_32f.
- Hunts for the comma/idle symbol (0xBC) at any bit offset and locks byte alignment onto it.
- Declares the link active after COMMA_COUNT consecutive aligned commas.
- Once active, delivers recovered bytes as an 8-bit word with a valid flag; commas are stripped as idle.

---
 rtl/serial_paralelo_pkg.sv | 15 +
 rtl/serial_paralelo_if.sv | 29 ++
 rtl/serial_paralelo_comma_detector.sv | 32 +++
 rtl/serial_paralelo.sv | 129 ++++++++++++
 tb/tb_serial_paralelo.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/serial_paralelo_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
// The serializer uses the same COMMA_SYM so both ends agree on the idle symbol.
package serial_paralelo_pkg;

   localparam int               SYM_W         = 8;
   localparam logic [SYM_W-1:0] COMMA_SYM     = 8'hBC;
   localparam int               COMMA_CNT_DEF = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_paralelo_if.sv
// Serial link bundle between the bit source and the deserializer.
// master: drives data_in, observes recovered byte/valid/active/strobe.
interface serial_paralelo_if #(
   parameter int WIDTH = 8
);

   logic             data_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             active;
   logic             byte_strobe;

   modport master (
      output data_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  byte_strobe
   );

   modport slave (
      input  data_in,
      output data_out,
      output valid_out,
      output active,
      output byte_strobe
   );

endinterface

// File: rtl/serial_paralelo_comma_detector.sv
// Bit shift register plus comma compare on the incoming serial stream.
// Ports: clk_32f, reset (async low), bit_in -> sr_next, is_comma.
module serial_paralelo_comma_detector
   import serial_paralelo_pkg::*;
#(
   parameter int               WIDTH = SYM_W,
   parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_SYM)
) (
   input  logic             clk_32f,
   input  logic             reset,
   input  logic             bit_in,
   output logic [WIDTH-1:0] sr_next,
   output logic             is_comma
);

   logic [WIDTH-1:0] sr_q;

   // Compares look at the window including this edge's bit.
   always_comb begin
      sr_next  = {sr_q[WIDTH-2:0], bit_in};
      is_comma = (sr_next == COMMA);
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_next;
      end
   end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: comma hunt, byte lock, payload recovery.
// Ports: clk_32f, reset (async low), bus (slave: data_in in; data_out,
// valid_out, active, byte_strobe out).
module serial_paralelo
   import serial_paralelo_pkg::*;
#(
   parameter int               WIDTH       = SYM_W,
   parameter logic [WIDTH-1:0] COMMA       = WIDTH'(COMMA_SYM),
   parameter int               COMMA_COUNT = COMMA_CNT_DEF
) (
   input  logic             clk_32f,
   input  logic             reset,
   serial_paralelo_if.slave bus
);

   localparam int            BW      = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);
   localparam logic [3:0]    CNT_TGT = 4'(COMMA_COUNT);

   logic [WIDTH-1:0] sr_next;
   logic             is_comma;

   state_e           state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]       comma_cnt_q, comma_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             active_q, active_d;
   logic             strobe_q, strobe_d;
   logic             boundary;

   serial_paralelo_comma_detector #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_det (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .bit_in   (bus.data_in),
      .sr_next  (sr_next),
      .is_comma (is_comma)
   );

   assign boundary = (bit_cnt_q == LAST);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
      comma_cnt_d = comma_cnt_q;
      data_d      = data_q;
      valid_d     = valid_q;
      active_d    = active_q;
      strobe_d    = 1'b0;

      unique case (state_q)
         SEARCH: begin
            valid_d  = 1'b0;
            active_d = 1'b0;
            if (is_comma) begin
               bit_cnt_d   = '0;
               comma_cnt_d = 4'd1;
               state_d     = (CNT_TGT == 4'd1) ? ACTIVE : ALIGN;
               active_d    = (CNT_TGT == 4'd1);
            end
         end
         ALIGN: begin
            valid_d = 1'b0;
            if (boundary) begin
               if (is_comma) begin
                  if (comma_cnt_q != CNT_TGT) begin
                     comma_cnt_d = comma_cnt_q + 4'd1;
                  end
                  if (comma_cnt_q + 4'd1 == CNT_TGT) begin
                     state_d  = ACTIVE;
                     active_d = 1'b1;
                  end
               end else begin
                  // A comma at a new offset would have matched here,
                  // but the window just failed, so plain hunt resumes.
                  comma_cnt_d = '0;
                  state_d     = SEARCH;
               end
            end
         end
         ACTIVE: begin
            if (boundary) begin
               strobe_d = 1'b1;
               if (is_comma) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = sr_next;
                  valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
            valid_d     = 1'b0;
            active_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q     <= SEARCH;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         active_q    <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         active_q    <= active_d;
         strobe_q    <= strobe_d;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.valid_out   = valid_q;
   assign bus.active      = active_q;
   assign bus.byte_strobe = strobe_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: serializer model feeding a scoreboard.
// Explicit timing checks around lock, hold, and asynchronous reset.
module tb_serial_paralelo;
   import serial_paralelo_pkg::*;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } exp_t;

   logic clk_32f = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic sb_en = 1'b0;
   logic [7:0] last_data;

   serial_paralelo_if #(.WIDTH(8)) bus();

   serial_paralelo #(
      .COMMA_COUNT (4)
   ) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put_bit(input logic b);
      bus.data_in = b;
      @(posedge clk_32f);
      #1;
   endtask

   task automatic send_sym(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
   endtask

   task automatic send_tracked(input logic [7:0] b);
      exp_t e;
      if (b == COMMA_SYM) begin
         e.v = 1'b0;
         e.d = last_data;
      end else begin
         e.v = 1'b1;
         e.d = b;
         last_data = b;
      end
      exp_q.push_back(e);
      send_sym(b);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) put_bit(1'($urandom_range(0, 1)));
      reset = 1'b1;
      last_data = 8'h00;
   endtask

   task automatic sb_drain();
      @(negedge clk_32f);
      #1;
      check("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d,
                          input logic v, input logic a);
      check({tag, "_data"}, 32'(bus.data_out), 32'(d));
      check({tag, "_valid"}, 32'(bus.valid_out), 32'(v));
      check({tag, "_active"}, 32'(bus.active), 32'(a));
   endtask

   always @(negedge clk_32f) begin
      if (sb_en && bus.active && bus.byte_strobe) begin
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_valid", 32'(bus.valid_out), 32'(mon_e.v));
            check("sb_data", 32'(bus.data_out), 32'(mon_e.d));
         end
      end
   end

   initial begin
      reset = 1'b0;
      bus.data_in = 1'b0;
      last_data = 8'h00;

      // reset hold with random bits
      repeat (3) put_bit(1'($urandom_range(0, 1)));
      chk_out("rst", 8'h00, 1'b0, 1'b0);
      check("rst_strobe", 32'(bus.byte_strobe), 32'd0);
      reset = 1'b1;
      repeat (3) send_sym(COMMA_SYM);
      for (int i = 0; i < 7; i++) put_bit(COMMA_SYM[7-i]);
      check("lock31_active", 32'(bus.active), 32'd0);
      put_bit(COMMA_SYM[0]);
      check("lock32_active", 32'(bus.active), 32'd1);
      check("lock32_valid", 32'(bus.valid_out), 32'd0);

      // misaligned lock at offset 3
      do_reset();
      repeat (3) put_bit(1'b0);
      repeat (3) send_sym(COMMA_SYM);
      for (int i = 0; i < 7; i++) put_bit(COMMA_SYM[7-i]);
      check("off34_active", 32'(bus.active), 32'd0);
      put_bit(COMMA_SYM[0]);
      check("off35_active", 32'(bus.active), 32'd1);
      for (int i = 0; i < 16; i++) begin
         put_bit(COMMA_SYM[7 - (i % 8)]);
         check("strobe_phase", 32'(bus.byte_strobe),
               32'((i % 8) == 7));
         check("idle_valid", 32'(bus.valid_out), 32'd0);
      end

      // failed lock then relock
      do_reset();
      repeat (3) send_sym(COMMA_SYM);
      send_sym(8'h55);
      check("fail_active", 32'(bus.active), 32'd0);
      repeat (3) send_sym(COMMA_SYM);
      check("relock3_active", 32'(bus.active), 32'd0);
      send_sym(COMMA_SYM);
      check("relock4_active", 32'(bus.active), 32'd1);

      // data recovery with hold checks
      sb_en = 1'b1;
      send_tracked(8'hA5);
      chk_out("a5", 8'hA5, 1'b1, 1'b1);
      check("a5_strobe", 32'(bus.byte_strobe), 32'd1);
      for (int i = 7; i >= 1; i--) begin
         put_bit(1'(8'h3C >> i));
         chk_out("a5_hold", 8'hA5, 1'b1, 1'b1);
      end
      exp_q.push_back('{v: 1'b1, d: 8'h3C});
      last_data = 8'h3C;
      put_bit(1'b0);
      chk_out("3c", 8'h3C, 1'b1, 1'b1);
      send_tracked(COMMA_SYM);
      chk_out("idle", 8'h3C, 1'b0, 1'b1);
      // 0x0B,0xC0 form 0xBC across the boundary
      send_tracked(8'h0B);
      send_tracked(8'hC0);
      chk_out("xbnd", 8'hC0, 1'b1, 1'b1);
      send_tracked(8'h5A);
      sb_drain();
      sb_en = 1'b0;

      // async reset mid-payload
      for (int i = 0; i < 4; i++) put_bit(1'b1);
      #2 reset = 1'b0;
      #1;
      chk_out("async", 8'h00, 1'b0, 1'b0);
      check("async_strobe", 32'(bus.byte_strobe), 32'd0);
      @(posedge clk_32f);
      #1 reset = 1'b1;
      send_sym(8'h77);
      chk_out("norelock", 8'h00, 1'b0, 1'b0);
      repeat (4) send_sym(COMMA_SYM);
      chk_out("relock", 8'h00, 1'b0, 1'b1);
      send_sym(8'h42);
      chk_out("post", 8'h42, 1'b1, 1'b1);

      // serializer loopback with idle gaps
      do_reset();
      repeat (4) send_sym(COMMA_SYM);
      check("loop_active", 32'(bus.active), 32'd1);
      sb_en = 1'b1;
      for (int b = 0; b < 256; b++) begin
         if ($urandom_range(0, 3) == 0) send_tracked(COMMA_SYM);
         send_tracked(8'(b));
      end
      sb_drain();
      sb_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
